// File: rtl/bus_sequencer_pkg.sv
// bus_sequencer_pkg: shared state encoding and bus constants for the sequencer
package bus_sequencer_pkg;
  typedef enum logic [2:0] {FETCH, EXEC, MEM, COMMIT, HALT} state_t;
  localparam logic [31:0] RESET_VECTOR_DEF = 32'hBFC00000;
  localparam logic [3:0] BE_ALL = 4'hF;
endpackage

// File: rtl/bus_watchdog.sv
// bus_watchdog: counts consecutive stalled bus cycles, fires on the TIMEOUT-th
module bus_watchdog #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic stall,
  output logic fire
);
  localparam int W = $clog2(TIMEOUT + 1);
  logic [W-1:0] cnt;
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt <= '0;
    else cnt <= stall ? cnt + 1'b1 : '0;
  assign fire = stall && (cnt == W'(TIMEOUT - 1));
endmodule

// File: rtl/bus_sequencer.sv
// bus_sequencer: multi-cycle fetch/exec/mem/commit bus sequencer.
// Define BUS_TIMEOUT_EN to add the waitrequest watchdog (bus_error, forced HALT).
module bus_sequencer
  import bus_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEF,
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  input  logic [3:0]  data_be,
  input  logic        data_rd,
  input  logic        data_wr,
  input  logic        halt_req,
  output logic [31:0] mem_address,
  output logic        mem_read,
  output logic        mem_write,
  output logic [3:0]  mem_byteenable,
  output logic [31:0] mem_writedata,
  input  logic        mem_waitrequest,
  input  logic [31:0] mem_readdata,
  output logic [31:0] instr,
  output logic [31:0] load_data,
  output logic        exec,
  output logic        pc_en,
  output logic        active,
  output logic        bus_error
);
  state_t state;
  logic [31:0] addr_q, wdata_q;
  logic [3:0] be_q;
  logic rd_q, wr_q, fire;
  logic unused_params;
  assign unused_params = ^{RESET_VECTOR, 32'(TIMEOUT)};
  // Strobes decode from state but are gated by reset so they drop asynchronously.
  assign mem_read = ~reset & ((state == FETCH) | ((state == MEM) & rd_q));
  assign mem_write = ~reset & (state == MEM) & wr_q;
  assign mem_address = (state == FETCH) ? pc : addr_q;
  assign mem_byteenable = (state == FETCH) ? BE_ALL : be_q;
  assign mem_writedata = wdata_q;
`ifdef BUS_TIMEOUT_EN
  bus_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
    .clk(clk),
    .reset(reset),
    .stall((mem_read | mem_write) & mem_waitrequest),
    .fire(fire)
  );
`else
  assign fire = 1'b0;
`endif
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= FETCH;
      instr <= '0;
      load_data <= '0;
      exec <= 1'b0;
      pc_en <= 1'b0;
      active <= 1'b1;
      bus_error <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      be_q <= '0;
      rd_q <= 1'b0;
      wr_q <= 1'b0;
    end else begin
      exec <= 1'b0;
      pc_en <= 1'b0;
      if (fire) begin
        state <= HALT;
        active <= 1'b0;
        bus_error <= 1'b1;
      end else begin
        case (state)
          FETCH: if (!mem_waitrequest) begin
            instr <= mem_readdata;
            exec <= 1'b1;
            state <= EXEC;
          end
          EXEC: begin
            addr_q <= data_addr;
            wdata_q <= data_wdata;
            be_q <= data_be;
            rd_q <= data_rd;
            wr_q <= data_wr & ~data_rd;
            state <= (data_rd | data_wr) ? MEM : COMMIT;
            pc_en <= ~(data_rd | data_wr);
          end
          MEM: if (!mem_waitrequest) begin
            if (rd_q) load_data <= mem_readdata;
            pc_en <= 1'b1;
            state <= COMMIT;
          end
          COMMIT: begin
            state <= halt_req ? HALT : FETCH;
            active <= ~halt_req;
          end
          default: state <= HALT;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_bus_sequencer.sv
// tb_bus_sequencer: directed scoreboard bench for bus_sequencer
module tb_bus_sequencer;
  logic clk = 1'b0, reset = 1'b1;
  logic [31:0] pc = 32'hBFC00000, data_addr = '0, data_wdata = '0, mem_readdata = '0;
  logic [3:0] data_be = '0;
  logic data_rd = 1'b0, data_wr = 1'b0, halt_req = 1'b0, mem_waitrequest = 1'b0;
  logic [31:0] mem_address, mem_writedata, instr, load_data;
  logic mem_read, mem_write, exec, pc_en, active, bus_error;
  logic [3:0] mem_byteenable;
  int vectors = 0, miscompares = 0;
  logic [31:0] exp_q[$];

  bus_sequencer #(.TIMEOUT(8)) dut (
    .clk(clk), .reset(reset), .pc(pc), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_be(data_be), .data_rd(data_rd), .data_wr(data_wr), .halt_req(halt_req),
    .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
    .mem_byteenable(mem_byteenable), .mem_writedata(mem_writedata),
    .mem_waitrequest(mem_waitrequest), .mem_readdata(mem_readdata), .instr(instr),
    .load_data(load_data), .exec(exec), .pc_en(pc_en), .active(active), .bus_error(bus_error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic pop_chk(input string tag, input logic [31:0] obs);
    if (exp_q.size() == 0) begin
      vectors++;
      miscompares++;
      $error("FAIL %s: scoreboard empty, observed %h", tag, obs);
    end else chk(tag, obs, exp_q.pop_front());
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  initial begin
    repeat (2) cyc();
    chk1("rst_rd", mem_read, 1'b0);
    chk1("rst_wr", mem_write, 1'b0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_load", load_data, 32'h0);
    chk1("rst_pc_en", pc_en, 1'b0);
    chk1("rst_exec", exec, 1'b0);
    chk1("rst_active", active, 1'b1);
    chk1("rst_bus_error", bus_error, 1'b0);
    reset = 1'b0;
    #1;
    // ALU instruction, zero wait states
    chk1("fetch_rd", mem_read, 1'b1);
    chk("fetch_addr", mem_address, 32'hBFC00000);
    chk("fetch_be", 32'(mem_byteenable), 32'hF);
    mem_readdata = 32'h00851020;
    exp_q.push_back(32'h00851020);
    cyc();
    chk1("alu_exec", exec, 1'b1);
    pop_chk("alu_instr", instr);
    chk1("alu_exec_no_rd", mem_read, 1'b0);
    chk1("alu_exec_no_pc_en", pc_en, 1'b0);
    cyc();
    chk1("alu_pc_en", pc_en, 1'b1);
    chk1("alu_commit_exec", exec, 1'b0);
    cyc();
    chk1("alu_pc_en_drop", pc_en, 1'b0);
    chk1("alu_refetch", mem_read, 1'b1);
    // Load with three wait states
    pc = 32'h104;
    mem_readdata = 32'h8C410000;
    exp_q.push_back(32'h8C410000);
    cyc();
    pop_chk("ld_instr", instr);
    data_rd = 1'b1;
    data_addr = 32'h1000;
    data_be = 4'hF;
    cyc();
    data_rd = 1'b0;
    data_addr = 32'hFFFF0000;
    mem_waitrequest = 1'b1;
    mem_readdata = 32'h11111111;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk1("ld_rd", mem_read, 1'b1);
      chk1("ld_no_wr", mem_write, 1'b0);
      chk("ld_addr", mem_address, 32'h1000);
      chk("ld_hold", load_data, 32'h0);
      chk1("ld_wait_pc_en", pc_en, 1'b0);
      if (i == 3) begin
        mem_waitrequest = 1'b0;
        mem_readdata = 32'hCAFEF00D;
        exp_q.push_back(32'hCAFEF00D);
      end
      cyc();
    end
    chk1("ld_pc_en", pc_en, 1'b1);
    chk1("ld_commit_rd", mem_read, 1'b0);
    pop_chk("ld_data", load_data);
    cyc();
    // Store with partial byte enables
    pc = 32'h108;
    mem_readdata = 32'hAC410004;
    exp_q.push_back(32'hAC410004);
    cyc();
    pop_chk("st_instr", instr);
    data_wr = 1'b1;
    data_be = 4'b0011;
    data_wdata = 32'hDEADBEEF;
    data_addr = 32'h2000;
    cyc();
    data_wr = 1'b0;
    data_wdata = '0;
    data_be = '0;
    #1;
    chk1("st_wr", mem_write, 1'b1);
    chk1("st_no_rd", mem_read, 1'b0);
    chk("st_addr", mem_address, 32'h2000);
    chk("st_be", 32'(mem_byteenable), 32'h3);
    chk("st_wdata", mem_writedata, 32'hDEADBEEF);
    cyc();
    chk1("st_pc_en", pc_en, 1'b1);
    chk1("st_commit_no_wr", mem_write, 1'b0);
    chk("st_load_keep", load_data, 32'hCAFEF00D);
    cyc();
    // Read and write requested together: read wins
    pc = 32'h10C;
    mem_readdata = 32'h00000123;
    exp_q.push_back(32'h00000123);
    cyc();
    pop_chk("rw_instr", instr);
    data_rd = 1'b1;
    data_wr = 1'b1;
    data_addr = 32'h3000;
    cyc();
    data_rd = 1'b0;
    data_wr = 1'b0;
    mem_readdata = 32'h12345678;
    exp_q.push_back(32'h12345678);
    #1;
    chk1("rw_rd", mem_read, 1'b1);
    chk1("rw_no_wr", mem_write, 1'b0);
    cyc();
    pop_chk("rw_load", load_data);
    cyc();
    // Halt
    pc = 32'h110;
    mem_readdata = 32'h08000000;
    exp_q.push_back(32'h08000000);
    cyc();
    pop_chk("halt_instr", instr);
    cyc();
    chk1("halt_pc_en", pc_en, 1'b1);
    chk1("halt_pre_active", active, 1'b1);
    halt_req = 1'b1;
    cyc();
    halt_req = 1'b0;
    chk1("halt_active", active, 1'b0);
    for (int i = 0; i < 20; i++) begin
      chk1("halt_idle", mem_read | mem_write, 1'b0);
      cyc();
    end
    chk1("halt_stays", active, 1'b0);
    // Reset asserted mid-MEM with waitrequest high
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    pc = 32'h200;
    mem_readdata = 32'h8C420000;
    exp_q.push_back(32'h8C420000);
    #1;
    chk("rst2_fetch_addr", mem_address, 32'h200);
    chk1("rst2_active", active, 1'b1);
    cyc();
    pop_chk("rst2_instr", instr);
    data_rd = 1'b1;
    data_addr = 32'h4000;
    cyc();
    data_rd = 1'b0;
    mem_waitrequest = 1'b1;
    #1;
    chk1("mid_mem_rd", mem_read, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    chk1("async_drop_rd", mem_read, 1'b0);
    chk("async_instr_clr", instr, 32'h0);
    cyc();
    pc = 32'h300;
    reset = 1'b0;
    #1;
    chk1("post_rst_fetch", mem_read, 1'b1);
    chk("post_rst_addr", mem_address, 32'h300);
    // Waitrequest stuck high from here on
`ifdef BUS_TIMEOUT_EN
    for (int i = 0; i < 8; i++) begin
      chk1("wd_pending", bus_error, 1'b0);
      cyc();
    end
    chk1("wd_bus_error", bus_error, 1'b1);
    chk1("wd_active", active, 1'b0);
    chk1("wd_no_rd", mem_read, 1'b0);
`else
    for (int i = 0; i < 20; i++) cyc();
    chk1("nowd_bus_error", bus_error, 1'b0);
    chk1("nowd_still_rd", mem_read, 1'b1);
    chk1("nowd_active", active, 1'b1);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
